// File: rtl/raster_frame_sequencer_if.sv
// Bundles the sequencer's frame control, upstream source, rasterizer handshake
// and the shared FB/ZB write port.
// "master" is the sequencer's view. "slave" is the view of the surrounding system.
interface raster_frame_sequencer_if #(
    parameter int unsigned TRI_W = 312
);
    // Frame control
    logic             frame_start;
    logic             clear_en;
    logic             fb_sel;
    logic             frame_done;
    logic             timeout_err;
    logic [15:0]      tri_count;

    // Upstream triangle source
    logic             src_valid;
    logic             src_last;
    logic [TRI_W-1:0] src_data;
    logic             src_ready;

    // Rasterizer handshake and its write requests
    logic             tri_valid;
    logic [TRI_W-1:0] tri_data;
    logic             rast_busy;
    logic [16:0]      rast_fb_addr;
    logic             rast_fb_we;
    logic [11:0]      rast_fb_pixel;
    logic [16:0]      rast_zb_addr;
    logic             rast_zb_we;
    logic [7:0]       rast_zb_data;

    // Muxed buffer write port
    logic [16:0]      fb_addr;
    logic             fb_we;
    logic [11:0]      fb_pixel;
    logic [16:0]      zb_addr;
    logic             zb_we;
    logic [7:0]       zb_data;

    modport master (
        input  frame_start, clear_en, src_valid, src_last, src_data, rast_busy,
        input  rast_fb_addr, rast_fb_we, rast_fb_pixel, rast_zb_addr, rast_zb_we, rast_zb_data,
        output src_ready, tri_valid, tri_data, fb_addr, fb_we, fb_pixel,
        output zb_addr, zb_we, zb_data, fb_sel, frame_done, timeout_err, tri_count
    );

    modport slave (
        output frame_start, clear_en, src_valid, src_last, src_data, rast_busy,
        output rast_fb_addr, rast_fb_we, rast_fb_pixel, rast_zb_addr, rast_zb_we, rast_zb_data,
        input  src_ready, tri_valid, tri_data, fb_addr, fb_we, fb_pixel,
        input  zb_addr, zb_we, zb_data, fb_sel, frame_done, timeout_err, tri_count
    );
endinterface

// File: rtl/raster_frame_sequencer.sv
// Per-frame controller in front of the rasterizer.
// A frame runs through these steps:
//   1. Optionally clear the FB and ZB.
//   2. Hand triangles one at a time to the rasterizer over the tri_valid/busy handshake.
//   3. Drain the last writes.
//   4. Pulse frame_done and flip the display buffer select.
module raster_frame_sequencer #(
    parameter int unsigned NUM_PIX     = 76800,
    parameter int unsigned TRI_W       = 312,
    parameter logic [11:0] CLEAR_COLOR = 12'h000,
    parameter logic [7:0]  CLEAR_Z     = 8'hFF,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned DRAIN_CYC   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    raster_frame_sequencer_if.master  bus
);

    localparam int unsigned CLR_W = $clog2(NUM_PIX);
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned DRN_W = $clog2(DRAIN_CYC + 1);

    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(NUM_PIX - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StIssue,
        StWait,
        StDrain,
        StDone
    } state_e;

    state_e           state_q;
    logic [CLR_W-1:0] clr_cnt_q;
    logic [ACK_W-1:0] ack_cnt_q;
    logic [DRN_W-1:0] drain_cnt_q;
    logic             last_q;
    logic [TRI_W-1:0] tri_data_q;
    logic             src_ready_q;
    logic             tri_valid_q;
    logic             frame_done_q;
    logic             fb_sel_q;
    logic             timeout_err_q;
    logic [15:0]      tri_count_q;
    logic             in_clear;

    // Sequencing FSM.
    // The handshake outputs are registered and updated on the same edge as the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            clr_cnt_q     <= '0;
            ack_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            last_q        <= 1'b0;
            tri_data_q    <= '0;
            src_ready_q   <= 1'b0;
            tri_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            fb_sel_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            tri_count_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.frame_start) begin
                        tri_count_q   <= '0;
                        timeout_err_q <= 1'b0;
                        clr_cnt_q     <= '0;
                        if (bus.clear_en) begin
                            state_q <= StClear;
                        end else begin
                            state_q     <= StFetch;
                            src_ready_q <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    if (clr_cnt_q == CLR_LAST) begin
                        state_q     <= StFetch;
                        src_ready_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                StFetch: begin
                    if (bus.src_valid && src_ready_q) begin
                        tri_data_q  <= bus.src_data;
                        last_q      <= bus.src_last;
                        src_ready_q <= 1'b0;
                        tri_valid_q <= 1'b1;
                        ack_cnt_q   <= '0;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.rast_busy) begin
                        tri_valid_q <= 1'b0;
                        state_q     <= StWait;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        // Rasterizer never acknowledged: drop the triangle uncounted
                        tri_valid_q   <= 1'b0;
                        timeout_err_q <= 1'b1;
                        if (last_q) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= '0;
                        end else begin
                            state_q     <= StFetch;
                            src_ready_q <= 1'b1;
                        end
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                StWait: begin
                    if (!bus.rast_busy) begin
                        if (tri_count_q != 16'hFFFF) begin
                            tri_count_q <= tri_count_q + 16'd1;
                        end
                        if (last_q) begin
                            state_q     <= StDrain;
                            drain_cnt_q <= '0;
                        end else begin
                            state_q     <= StFetch;
                            src_ready_q <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == DRN_LAST) begin
                        state_q      <= StDone;
                        frame_done_q <= 1'b1;
                        fb_sel_q     <= ~fb_sel_q;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Write-port mux.
    // The clear engine owns the port only while clearing.
    // Otherwise rasterizer writes pass straight through with no added latency.
    always_comb begin
        in_clear = (state_q == StClear);
        if (in_clear) begin
            bus.fb_addr  = 17'(clr_cnt_q);
            bus.fb_we    = 1'b1;
            bus.fb_pixel = CLEAR_COLOR;
            bus.zb_addr  = 17'(clr_cnt_q);
            bus.zb_we    = 1'b1;
            bus.zb_data  = CLEAR_Z;
        end else begin
            bus.fb_addr  = bus.rast_fb_addr;
            bus.fb_we    = bus.rast_fb_we;
            bus.fb_pixel = bus.rast_fb_pixel;
            bus.zb_addr  = bus.rast_zb_addr;
            bus.zb_we    = bus.rast_zb_we;
            bus.zb_data  = bus.rast_zb_data;
        end
    end

    assign bus.src_ready   = src_ready_q;
    assign bus.tri_valid   = tri_valid_q;
    assign bus.tri_data    = tri_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.fb_sel      = fb_sel_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.tri_count   = tri_count_q;

endmodule

// File: tb/tb_raster_frame_sequencer.sv
// Directed bench for raster_frame_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_raster_frame_sequencer;

    localparam int TRI_W = 312;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    raster_frame_sequencer_if #(.TRI_W(TRI_W)) bus_if ();

    raster_frame_sequencer #(.TRI_W(TRI_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field layout is opaque to the sequencer; only bit-exact transport matters.
    function automatic logic [TRI_W-1:0] mk_tri(input logic [15:0] x0, input logic [15:0] y0,
                                                 input logic [15:0] x1, input logic [15:0] y1,
                                                 input logic [15:0] x2, input logic [15:0] y2,
                                                 input logic [7:0] z);
        logic [TRI_W-1:0] t;
        t = '0;
        t[311:216] = {x0, y0, x1, y1, x2, y2};
        t[215:192] = {z, z, z};
        t[191:0]   = {6{x0 ^ y2, y1 + x1}};
        return t;
    endfunction

    task automatic start_frame(input logic clr);
        bus_if.frame_start = 1'b1;
        bus_if.clear_en    = clr;
        @(negedge clk);
        bus_if.frame_start = 1'b0;
        bus_if.clear_en    = 1'b0;
    endtask

    // Offer one triangle, act as the rasterizer, and check the handshake throughout.
    // lat = cycles before busy rises; blen = cycles busy stays high.
    // poke = pulse frame_start during busy.
    task automatic serve_tri(input logic [TRI_W-1:0] d, input logic last, input int lat,
                             input int blen, input bit poke);
        int k;
        int bad;
        int bad_pt;
        logic [16:0] a;
        bus_if.src_data  = d;
        bus_if.src_last  = last;
        bus_if.src_valid = 1'b1;
        k = 0;
        while (bus_if.src_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (bus_if.src_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL src_ready_wait: src_ready=%b want 1", bus_if.src_ready);
        end
        @(negedge clk);
        bus_if.src_valid = 1'b0;
        bus_if.src_last  = 1'b0;
        vectors++;
        if (bus_if.tri_valid !== 1'b1 || bus_if.tri_data !== d) begin
            miscompares++;
            $display("FAIL issue: tri_valid=%b data_match=%b want 1/1", bus_if.tri_valid,
                     bus_if.tri_data === d);
        end
        bad = 0;
        bad_pt = 0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (bus_if.tri_valid !== 1'b1 || bus_if.tri_data !== d || bus_if.src_ready !== 1'b0)
                bad++;
        end
        bus_if.rast_busy = 1'b1;
        for (int i = 0; i < blen; i++) begin
            @(negedge clk);
            if (bus_if.tri_valid !== 1'b0 || bus_if.src_ready !== 1'b0) bad++;
            if (poke) begin
                bus_if.frame_start = (i == 0);
                bus_if.clear_en    = (i == 0);
            end
            a = 17'h00100 + 17'(i);
            bus_if.rast_fb_addr = a;
            #1;
            if (bus_if.fb_addr !== a || bus_if.fb_we !== bus_if.rast_fb_we) bad_pt++;
        end
        bus_if.frame_start = 1'b0;
        bus_if.clear_en    = 1'b0;
        bus_if.rast_busy   = 1'b0;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL tri_hold_overlap: %0d bad cycles, want 0", bad);
        end
        vectors++;
        if (bad_pt != 0) begin
            miscompares++;
            $display("FAIL busy_passthrough: %0d bad cycles, want 0", bad_pt);
        end
    endtask

    // Called on the falling edge where busy was just dropped for the last triangle.
    task automatic wait_done(input logic exp_sel, input logic [15:0] exp_count, input logic exp_to);
        int k;
        logic sel_before;
        sel_before = bus_if.fb_sel;
        k = 0;
        while (bus_if.frame_done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        // 1 cycle to leave WAIT plus 8 drain cycles
        vectors++;
        if (k != 9) begin
            miscompares++;
            $display("FAIL done_latency: got %0d cycles want 9", k);
        end
        vectors++;
        if (bus_if.fb_sel !== exp_sel || sel_before !== ~exp_sel) begin
            miscompares++;
            $display("FAIL fb_sel: before=%b at_done=%b want %b->%b", sel_before, bus_if.fb_sel,
                     ~exp_sel, exp_sel);
        end
        vectors++;
        if (bus_if.tri_count !== exp_count) begin
            miscompares++;
            $display("FAIL tri_count: got %0d want %0d", bus_if.tri_count, exp_count);
        end
        vectors++;
        if (bus_if.timeout_err !== exp_to) begin
            miscompares++;
            $display("FAIL timeout_err: got %b want %b", bus_if.timeout_err, exp_to);
        end
        @(negedge clk);
        vectors++;
        if (bus_if.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: frame_done=%b want 0", bus_if.frame_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus_if.src_ready, bus_if.tri_valid, bus_if.fb_we, bus_if.zb_we, bus_if.fb_sel,
             bus_if.frame_done, bus_if.timeout_err} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000000", {bus_if.src_ready, bus_if.tri_valid,
                     bus_if.fb_we, bus_if.zb_we, bus_if.fb_sel, bus_if.frame_done,
                     bus_if.timeout_err});
        end
        vectors++;
        if (bus_if.tri_count !== 16'd0 || bus_if.tri_data !== '0 || bus_if.fb_addr !== 17'd0 ||
            bus_if.zb_addr !== 17'd0 || bus_if.fb_pixel !== 12'd0 || bus_if.zb_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_values: tri_count=%0d fb_addr=%0d want 0", bus_if.tri_count,
                     bus_if.fb_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_and_single();
        int n;
        int bad_addr;
        int bad_data;
        int bad_hs;
        // Rasterizer noise on the write inputs must not leak during clear
        bus_if.rast_fb_addr  = 17'h1ABCD;
        bus_if.rast_fb_pixel = 12'hABC;
        bus_if.rast_zb_addr  = 17'h0F0F0;
        bus_if.rast_zb_data  = 8'h12;
        start_frame(1'b1);
        n = 0;
        bad_addr = 0;
        bad_data = 0;
        bad_hs = 0;
        while (bus_if.fb_we === 1'b1 && n < 80000) begin
            if (bus_if.fb_addr !== 17'(n) || bus_if.zb_addr !== 17'(n)) bad_addr++;
            if (bus_if.fb_pixel !== 12'h000 || bus_if.zb_data !== 8'hFF || bus_if.zb_we !== 1'b1)
                bad_data++;
            if (bus_if.src_ready !== 1'b0 || bus_if.tri_valid !== 1'b0) bad_hs++;
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 76800) begin
            miscompares++;
            $display("FAIL clear_len: got %0d write cycles want 76800", n);
        end
        vectors++;
        if (bad_addr != 0) begin
            miscompares++;
            $display("FAIL clear_addr_order: %0d bad addresses want 0", bad_addr);
        end
        vectors++;
        if (bad_data != 0) begin
            miscompares++;
            $display("FAIL clear_data: %0d bad cycles want 0", bad_data);
        end
        vectors++;
        if (bad_hs != 0) begin
            miscompares++;
            $display("FAIL clear_handshake: %0d bad cycles want 0", bad_hs);
        end
        vectors++;
        if (bus_if.src_ready !== 1'b1 || bus_if.fb_addr !== 17'h1ABCD || bus_if.zb_data !== 8'h12)
        begin
            miscompares++;
            $display("FAIL post_clear: src_ready=%b fb_addr=%h zb_data=%h want 1/1abcd/12",
                     bus_if.src_ready, bus_if.fb_addr, bus_if.zb_data);
        end
        serve_tri(mk_tri(16'd160, 16'd110, 16'd150, 16'd130, 16'd170, 16'd130, 8'd50), 1'b1, 3, 5,
                  1'b0);
        wait_done(1'b1, 16'd1, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_frame(1'b0);
        serve_tri(mk_tri(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 8'd1), 1'b0, 0, 1, 1'b0);
        serve_tri(mk_tri(16'd11, 16'd21, 16'd31, 16'd41, 16'd51, 16'd61, 8'd2), 1'b0, 7, 4, 1'b0);
        serve_tri(mk_tri(16'd12, 16'd22, 16'd32, 16'd42, 16'd52, 16'd62, 8'd3), 1'b1, 10, 2, 1'b0);
        wait_done(1'b0, 16'd3, 1'b0);
    endtask

    task automatic test_timeout();
        int n;
        logic [TRI_W-1:0] d;
        d = mk_tri(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 8'd7);
        start_frame(1'b0);
        bus_if.src_data  = d;
        bus_if.src_last  = 1'b0;
        bus_if.src_valid = 1'b1;
        n = 0;
        while (bus_if.src_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus_if.src_valid = 1'b0;
        n = 0;
        while (bus_if.tri_valid === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 64) begin
            miscompares++;
            $display("FAIL timeout_len: tri_valid high %0d cycles want 64", n);
        end
        vectors++;
        if (bus_if.timeout_err !== 1'b1 || bus_if.src_ready !== 1'b1 || bus_if.tri_count !== 16'd0)
        begin
            miscompares++;
            $display("FAIL timeout_advance: err=%b src_ready=%b count=%0d want 1/1/0",
                     bus_if.timeout_err, bus_if.src_ready, bus_if.tri_count);
        end
        serve_tri(mk_tri(16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 8'd3), 1'b1, 2, 3, 1'b0);
        wait_done(1'b1, 16'd1, 1'b1);
    endtask

    task automatic test_reset_mid_clear();
        int k;
        bus_if.rast_fb_addr  = '0;
        bus_if.rast_fb_pixel = '0;
        bus_if.rast_zb_addr  = '0;
        bus_if.rast_zb_data  = '0;
        bus_if.rast_fb_we    = 1'b0;
        bus_if.rast_zb_we    = 1'b0;
        start_frame(1'b1);
        k = 0;
        while (bus_if.fb_addr !== 17'd1000 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (bus_if.fb_addr !== 17'd1000 || bus_if.fb_we !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_clear_reach: fb_addr=%0d we=%b want 1000/1", bus_if.fb_addr,
                     bus_if.fb_we);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus_if.fb_we, bus_if.zb_we, bus_if.fb_sel, bus_if.frame_done, bus_if.src_ready,
             bus_if.tri_valid, bus_if.timeout_err} !== 7'b0 || bus_if.fb_addr !== 17'd0 ||
            bus_if.zb_data !== 8'd0 || bus_if.tri_count !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: fb_we=%b fb_sel=%b fb_addr=%0d zb_data=%h want all 0",
                     bus_if.fb_we, bus_if.fb_sel, bus_if.fb_addr, bus_if.zb_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_frame(1'b1);
        vectors++;
        if (bus_if.fb_we !== 1'b1 || bus_if.fb_addr !== 17'd0) begin
            miscompares++;
            $display("FAIL clear_restart0: we=%b addr=%0d want 1/0", bus_if.fb_we, bus_if.fb_addr);
        end
        @(negedge clk);
        vectors++;
        if (bus_if.fb_addr !== 17'd1) begin
            miscompares++;
            $display("FAIL clear_restart1: addr=%0d want 1", bus_if.fb_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough_ignore();
        bus_if.rast_fb_addr  = 17'h00123;
        bus_if.rast_fb_we    = 1'b1;
        bus_if.rast_fb_pixel = 12'h5A5;
        bus_if.rast_zb_addr  = 17'h1FFFF;
        bus_if.rast_zb_we    = 1'b1;
        bus_if.rast_zb_data  = 8'h3C;
        #1;
        vectors++;
        if (bus_if.fb_addr !== 17'h00123 || bus_if.fb_we !== 1'b1 || bus_if.fb_pixel !== 12'h5A5 ||
            bus_if.zb_addr !== 17'h1FFFF || bus_if.zb_we !== 1'b1 || bus_if.zb_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL idle_passthrough: fb_addr=%h pixel=%h zb_addr=%h zb_data=%h",
                     bus_if.fb_addr, bus_if.fb_pixel, bus_if.zb_addr, bus_if.zb_data);
        end
        @(negedge clk);
        start_frame(1'b0);
        vectors++;
        if (bus_if.src_ready !== 1'b1 || bus_if.fb_addr !== 17'h00123 ||
            bus_if.fb_pixel !== 12'h5A5) begin
            miscompares++;
            $display("FAIL no_clear_frame: src_ready=%b fb_addr=%h pixel=%h want 1/00123/5a5",
                     bus_if.src_ready, bus_if.fb_addr, bus_if.fb_pixel);
        end
        serve_tri(mk_tri(16'd100, 16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 8'd9), 1'b1, 1, 4,
                  1'b1);
        wait_done(1'b1, 16'd1, 1'b0);
        bus_if.rast_fb_we = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (bus_if.src_ready !== 1'b0 || bus_if.fb_we !== 1'b0 || bus_if.tri_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_not_queued: src_ready=%b fb_we=%b tri_valid=%b want 0/0/0",
                     bus_if.src_ready, bus_if.fb_we, bus_if.tri_valid);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus_if.frame_start   = 1'b0;
        bus_if.clear_en      = 1'b0;
        bus_if.src_valid     = 1'b0;
        bus_if.src_last      = 1'b0;
        bus_if.src_data      = '0;
        bus_if.rast_busy     = 1'b0;
        bus_if.rast_fb_addr  = '0;
        bus_if.rast_fb_we    = 1'b0;
        bus_if.rast_fb_pixel = '0;
        bus_if.rast_zb_addr  = '0;
        bus_if.rast_zb_we    = 1'b0;
        bus_if.rast_zb_data  = '0;
        test_reset();
        test_clear_and_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid_clear();
        test_passthrough_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
